// File: rtl/muldiv_iter.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, UNROLL bits per cycle, registered result.
module muldiv_iter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned UNROLL       = 1,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            valid_in,
  input  logic [2:0]      op_in,
  input  logic            word_in,
  input  logic [8:0]      rd_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  output logic            busy_out,
  output logic            valid_out,
  output logic [8:0]      rd_out,
  output logic [XLEN-1:0] result_out
);

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [2*XLEN-1:0] dbl_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  if ((UNROLL == 0) || ((32 % UNROLL) != 0)) begin : gen_unroll_check
    $error("muldiv_iter: UNROLL must divide 32");
  end
  if ((XLEN != 32) && (XLEN != 64)) begin : gen_xlen_check
    $error("muldiv_iter: XLEN must be 32 or 64");
  end

  localparam xlen_t MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam xlen_t MinWord = xlen_t'($signed(32'h8000_0000));

  function automatic xlen_t sext32(input logic [31:0] v);
    return xlen_t'($signed(v));
  endfunction

  state_e     state_q, state_d;
  logic [6:0] count_q;
  dbl_t       acc_q;
  xlen_t      sh_q, opb_q;
  logic [2:0] op_q;
  logic       word_q, neg_q, spec_q;
  logic [8:0] rd_q, rd_out_q;
  logic       valid_q;
  xlen_t      result_q;
  logic       accept;

  // Operand decode on the accept cycle
  logic       word_eff, a_signed, b_signed, a_neg, b_neg, b_zero, ovf, special, neg_d;
  xlen_t      a_ext, b_ext, a_sx, a_mag, b_mag, a_start, spec_res;
  logic [6:0] n_iter;

  assign word_eff = (XLEN == 64) ? word_in : 1'b0;

  always_comb begin
    a_signed = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    b_signed = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    a_sx     = word_eff ? sext32(rs1_value_in[31:0]) : rs1_value_in;
    a_ext    = word_eff ? (a_signed ? a_sx : xlen_t'(rs1_value_in[31:0])) : rs1_value_in;
    b_ext    = word_eff ? (b_signed ? sext32(rs2_value_in[31:0]) : xlen_t'(rs2_value_in[31:0]))
                        : rs2_value_in;
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? xlen_t'(-a_ext) : a_ext;
    b_mag    = b_neg ? xlen_t'(-b_ext) : b_ext;
    b_zero   = (b_ext == '0);
    ovf      = !op_in[0] && (a_ext == (word_eff ? MinWord : MinFull)) && (b_ext == '1);
    special  = FAST_SPECIAL && op_in[2] && (b_zero || ovf);
    if (b_zero) spec_res = op_in[1] ? a_sx : '1;
    else        spec_res = op_in[1] ? '0 : a_ext;
    // Zero divisor leaves an all-ones quotient magnitude that must not be negated
    if (op_in[2]) neg_d = op_in[1] ? a_neg : ((a_neg ^ b_neg) & !b_zero);
    else          neg_d = a_neg ^ b_neg;
    // Left-align word operands so the MSB-first loops see bit 31 first
    a_start  = word_eff ? (a_mag << (XLEN - 32)) : a_mag;
    n_iter   = word_eff ? 7'(32 / UNROLL) : 7'(XLEN / UNROLL);
  end

  // UNROLL iteration steps per cycle
  dbl_t          acc_n;
  xlen_t         sh_n;
  logic [XLEN:0] rem_t;

  always_comb begin
    acc_n = acc_q;
    sh_n  = sh_q;
    rem_t = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (op_q[2]) begin
        rem_t = {acc_n[XLEN-1:0], sh_n[XLEN-1]};
        sh_n  = sh_n << 1;
        if (rem_t >= {1'b0, opb_q}) begin
          rem_t   = rem_t - {1'b0, opb_q};
          sh_n[0] = 1'b1;
        end
        acc_n = dbl_t'(rem_t);
      end else begin
        acc_n = (acc_n << 1) + (sh_n[XLEN-1] ? dbl_t'(opb_q) : dbl_t'(0));
        sh_n  = sh_n << 1;
      end
    end
  end

  // Sign fix-up and result selection for the DONE cycle
  dbl_t  prod;
  xlen_t quo, rem, hi, sel, fin;

  always_comb begin
    prod = neg_q ? dbl_t'(-acc_q) : acc_q;
    quo  = neg_q ? xlen_t'(-sh_q) : sh_q;
    rem  = neg_q ? xlen_t'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    hi   = word_q ? xlen_t'(prod[63:32]) : prod[2*XLEN-1:XLEN];
    if (op_q[2])               sel = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'd0) sel = prod[XLEN-1:0];
    else                       sel = hi;
    if (spec_q) fin = sh_q;
    else        fin = word_q ? sext32(sel[31:0]) : sel;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_in && !flush_in && !stall_in) begin
          accept  = 1'b1;
          state_d = special ? StDone : StRun;
        end
      end
      StRun:   if (count_q == 7'd1) state_d = StDone;
      StDone:  if (valid_q && !stall_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_in) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q   <= '0;
        sh_q    <= special ? spec_res : a_start;
        opb_q   <= b_mag;
        op_q    <= op_in;
        word_q  <= word_eff;
        neg_q   <= neg_d;
        spec_q  <= special;
        rd_q    <= rd_in;
        count_q <= n_iter;
      end else if (state_q == StRun) begin
        acc_q   <= acc_n;
        sh_q    <= sh_n;
        count_q <= count_q - 7'd1;
      end else if (state_q == StDone) begin
        if (!valid_q) begin
          result_q <= fin;
          rd_out_q <= rd_q;
          valid_q  <= 1'b1;
        end else if (!stall_in) begin
          valid_q <= 1'b0;
        end
      end
      if (flush_in) valid_q <= 1'b0;
    end
  end

  assign busy_out   = (state_q == StRun);
  assign valid_out  = valid_q;
  assign rd_out     = rd_out_q;
  assign result_out = result_q;

endmodule
